// File: rtl/csa_pkg.sv
// csa_pkg: shared mode encoding and pipeline depth helper for the carry-skip adder
package csa_pkg;

    typedef enum logic {ADD = 1'b0, SUB = 1'b1} mode_e;

    function automatic int nblk(int width, int block);
        return width / block;
    endfunction

endpackage

// File: rtl/csa_pipe_adder_if.sv
// csa_pipe_adder_if: valid/ready operand and result streams of the pipelined adder
interface csa_pipe_adder_if #(parameter int WIDTH = 32) ();

    logic             in_valid, in_ready, cin, sub;
    logic [WIDTH-1:0] op1, op2;
    logic             out_valid, out_ready, cout, ovf;
    logic [WIDTH-1:0] sum;

    modport master (output in_valid, op1, op2, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, op1, op2, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);

endinterface

// File: rtl/csa_skip_block.sv
// csa_skip_block: one BLOCK-bit ripple segment whose carry out bypasses the ripple when all bits propagate
module csa_skip_block #(parameter int BLOCK = 8) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             c_in,
    output logic [BLOCK-1:0] s,
    output logic             c_out,
    output logic             c_msb
);

    logic [BLOCK-1:0] g, p;
    logic [BLOCK:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c = '0;
        c[0] = c_in;
        for (int i = 0; i < BLOCK; i++) c[i+1] = g[i] | (p[i] & c[i]);
    end

    assign s     = p ^ c[BLOCK-1:0];
    assign c_out = (&p) ? c_in : c[BLOCK];
    assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/csa_pipe_adder.sv
// csa_pipe_adder: pipelined carry-skip add/sub, one BLOCK-bit slice resolved per stage, bubble-collapsing valid/ready
module csa_pipe_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input logic              clk,
    input logic              rst_n,
    csa_pipe_adder_if.slave  io
);

    localparam int NBLK = nblk(WIDTH, BLOCK);

    if (WIDTH % BLOCK != 0 || BLOCK < 2) begin : g_bad
        $error("csa_pipe_adder: WIDTH must be a multiple of BLOCK and BLOCK >= 2");
    end

    // ra holds {resolved sum, unresolved a} rotated so the next block always sits in the low bits
    logic [WIDTH-1:0]            ra [NBLK];
    logic [WIDTH-1:0]            rb [NBLK];
    logic [NBLK-1:0]             v, rc;
    logic                        rm;
    logic [WIDTH-1:0]            ai [NBLK];
    logic [WIDTH-1:0]            bi [NBLK];
    logic [NBLK-1:0]             ci, vi, en, co, cm;
    logic [NBLK-1:0][BLOCK-1:0]  s;
    logic                        unused_ok;

    always_comb begin
        ai[0] = io.op1;
        bi[0] = (mode_e'(io.sub) == SUB) ? ~io.op2 : io.op2;
        ci[0] = (mode_e'(io.sub) == SUB) ? 1'b1 : io.cin;
        vi[0] = io.in_valid;
        for (int k = 1; k < NBLK; k++) begin
            ai[k] = ra[k-1];
            bi[k] = rb[k-1];
            ci[k] = rc[k-1];
            vi[k] = v[k-1];
        end
        for (int k = 0; k < NBLK; k++) en[k] = io.out_ready | ~&(v | NBLK'((1 << k) - 1));
    end

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        csa_skip_block #(.BLOCK(BLOCK)) u_blk (
            .a     (ai[k][BLOCK-1:0]),
            .b     (bi[k][BLOCK-1:0]),
            .c_in  (ci[k]),
            .s     (s[k]),
            .c_out (co[k]),
            .c_msb (cm[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v  <= '0;
            rc <= '0;
            rm <= 1'b0;
            for (int k = 0; k < NBLK; k++) begin
                ra[k] <= '0;
                rb[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NBLK; k++) begin
                if (en[k]) v[k] <= vi[k];
                if (en[k] && vi[k]) begin
                    ra[k] <= (WIDTH'(s[k]) << (WIDTH - BLOCK)) | (ai[k] >> BLOCK);
                    rb[k] <= bi[k] >> BLOCK;
                    rc[k] <= co[k];
                end
            end
            if (en[NBLK-1] && vi[NBLK-1]) rm <= cm[NBLK-1];
        end
    end

    assign io.in_ready  = en[0];
    assign io.out_valid = v[NBLK-1];
    assign io.sum       = ra[NBLK-1];
    assign io.cout      = rc[NBLK-1];
    assign io.ovf       = rm ^ rc[NBLK-1];
    assign unused_ok    = ^{rb[NBLK-1], cm};

endmodule
